ins_cache: RTL
==============

# ins_cache

Direct-mapped, one-word-per-line instruction cache sitting directly upstream of the fetch stage. It accepts PC requests from fetch, returns the 32-bit instruction on a hit in one cycle, and on a miss fetches the word from the memory controller, fills the line, then returns it. A ROB jump cancels any response still owed to fetch, so fetch never receives an instruction for a PC it has abandoned.

## Interface

Parameters:
- INDEX_BITS, 6, log2 of line count (64 lines); tag = pc[31:INDEX_BITS+2], index = pc[INDEX_BITS+1:2].

Ports:
- clk  in  1  single clock; all state on posedge.
- reset  in  1  synchronous, active-low: sampled on posedge clk, reset when 0.
- ready  in  1  global enable; when 0 all state and outputs hold.
- fetch_req  in  1  fetch requests instruction at fetch_pc (level, held until served).
- fetch_pc  in  32  requested PC; bits [1:0] ignored.
- ins_valid  out  1  one-cycle pulse: ins holds instruction for the last accepted request.
- ins  out  32  instruction word.
- jump  in  1  ROB redirect; kills the outstanding request.
- mc_req  out  1  read request to memory controller, held until mc_valid.
- mc_addr  out  32  word-aligned address {pc[31:2],2'b00}, stable while mc_req=1.
- mc_valid  in  1  memory controller returns mc_data this cycle.
- mc_data  in  32  returned instruction word.

## Operation

- Storage: per line valid bit, tag, 32-bit data. Reset clears all valid bits; data/tag contents are don't-care.
- States: IDLE, MISS.
- IDLE, ready=1, jump=0, fetch_req=1, ins_valid currently 0: request accepted.
  - Hit (valid && tag match): ins <= data, ins_valid <= 1; stay IDLE.
  - Miss: latch pc, mc_req <= 1, mc_addr <= aligned pc, killed <= 0; go MISS.
- IDLE with ins_valid currently 1: fetch_req ignored this cycle (fetch still shows the old request for one cycle after a response); ins_valid <= 0.
- MISS, mc_valid=1: write line (valid=1, tag, data=mc_data) at latched index; mc_req <= 0; if killed=0 then ins <= mc_data, ins_valid <= 1; go IDLE.
- MISS, mc_valid=0: hold mc_req/mc_addr.
- jump=1 (any state, ready=1): ins_valid <= 0; no request accepted that cycle; in MISS set killed <= 1 (memory read cannot be cancelled; line is still filled on return, no response issued). jump coinciding with mc_valid: fill line, no response, go IDLE.
- Only one outstanding memory request ever.
- reset=0 at any time, including mid-miss: state IDLE, all valid bits 0, mc_req=0, ins_valid=0, ins=0, mc_addr=0, killed=0; a late mc_valid after reset is ignored in IDLE.
- ready=0: nothing changes; mc_valid is not sampled (memory controller is gated by the same ready).

## Timing

- Reset values: ins_valid=0, ins=0, mc_req=0, mc_addr=0.
- Hit latency: fetch_req sampled at edge t -> ins_valid=1 after edge t, low after t+1.
- Miss: fetch_req sampled at edge t -> mc_req=1 after t; mc_valid sampled at edge u>t -> ins_valid=1 and mc_req=0 after u.
- Minimum request spacing: one response per two cycles (response cycle blanks acceptance).
- ins_valid never high two consecutive cycles.

## Test plan

- Cold miss then hit: reset, fetch_req pc=0x0000_0010, mc_valid 3 cycles after mc_req with data 0x0000_0513 -> mc_addr=0x10, ins_valid one cycle with ins=0x0000_0513; re-request 0x10 -> ins_valid one cycle after, mc_req stays 0.
- Conflict eviction: fill 0x10, then request 0x110 (same index, INDEX_BITS=6) -> miss, mc_addr=0x110; request 0x10 again -> miss again.
- Jump during miss: request 0x20, assert jump one cycle while mc_req=1, return 0xDEADBEEF -> no ins_valid; later request 0x20 hits with 0xDEADBEEF.
- No duplicate response: fetch_req held high continuously at 0x10 (hit) -> ins_valid pulses at most every other cycle, never back-to-back.
- Reset mid-miss: request 0x40, drop reset (0) while mc_req=1, then mc_valid arrives -> no ins_valid, mc_req=0, next request 0x40 misses.
- Ready stall: ready=0 for 5 cycles with a hit pending -> outputs frozen; response appears one cycle after ready returns to 1.

Source files
------------

// File: rtl/ins_cache_if.sv
// ins_cache_if: fetch-side and memory-controller-side signals of the instruction cache
interface ins_cache_if;
  logic fetch_req;
  logic [31:0] fetch_pc;
  logic ins_valid;
  logic [31:0] ins;
  logic jump;
  logic mc_req;
  logic [31:0] mc_addr;
  logic mc_valid;
  logic [31:0] mc_data;
  modport master(
    output fetch_req, fetch_pc, jump, mc_valid, mc_data,
    input ins_valid, ins, mc_req, mc_addr
  );
  modport slave(
    input fetch_req, fetch_pc, jump, mc_valid, mc_data,
    output ins_valid, ins, mc_req, mc_addr
  );
endinterface

// File: rtl/ins_cache.sv
// ins_cache: direct-mapped one-word-per-line instruction cache with jump-cancelled responses
module ins_cache #(
  parameter int INDEX_BITS = 6
) (
  input logic clk,
  input logic reset,
  input logic ready,
  ins_cache_if.slave bus
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;
  typedef enum logic {IDLE, MISS} state_t;
  state_t state, state_n;
  logic [LINES-1:0] valid;
  logic [TAG_BITS-1:0] tag_mem [LINES];
  logic [31:0] data_mem [LINES];
  logic killed, killed_n, ins_valid_n, mc_req_n, fill, hit;
  logic [31:0] ins_n, mc_addr_n, pc_al;
  logic [INDEX_BITS-1:0] req_idx, fill_idx;
  assign pc_al = bus.fetch_pc & ~32'h3;
  assign req_idx = pc_al[INDEX_BITS+1:2];
  assign fill_idx = bus.mc_addr[INDEX_BITS+1:2];
  assign hit = valid[req_idx] && tag_mem[req_idx] == pc_al[31:INDEX_BITS+2];
  // next state and outputs; a response cycle blanks acceptance, jump kills any owed response
  always_comb begin
    state_n = state;
    ins_n = bus.ins;
    ins_valid_n = 1'b0;
    mc_req_n = bus.mc_req;
    mc_addr_n = bus.mc_addr;
    killed_n = killed;
    fill = 1'b0;
    if (state == IDLE) begin
      if (!bus.jump && bus.fetch_req && !bus.ins_valid) begin
        if (hit) begin
          ins_n = data_mem[req_idx];
          ins_valid_n = 1'b1;
        end else begin
          mc_req_n = 1'b1;
          mc_addr_n = pc_al;
          killed_n = 1'b0;
          state_n = MISS;
        end
      end
    end else if (bus.mc_valid) begin
      fill = 1'b1;
      mc_req_n = 1'b0;
      state_n = IDLE;
      if (!killed && !bus.jump) begin
        ins_n = bus.mc_data;
        ins_valid_n = 1'b1;
      end
    end else if (bus.jump) begin
      killed_n = 1'b1;
    end
  end
  // state register, frozen while ready is low
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else if (ready) state <= state_n;
  end
  // output and kill registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.ins_valid <= 1'b0;
      bus.ins <= '0;
      bus.mc_req <= 1'b0;
      bus.mc_addr <= '0;
      killed <= 1'b0;
    end else if (ready) begin
      bus.ins_valid <= ins_valid_n;
      bus.ins <= ins_n;
      bus.mc_req <= mc_req_n;
      bus.mc_addr <= mc_addr_n;
      killed <= killed_n;
    end
  end
  // line valid bits; only these need clearing on reset
  always_ff @(posedge clk) begin
    if (!reset) valid <= '0;
    else if (ready && fill) valid[fill_idx] <= 1'b1;
  end
  // tag and data storage, written when a memory read returns (even if killed)
  always_ff @(posedge clk) begin
    if (reset && ready && fill) begin
      tag_mem[fill_idx] <= bus.mc_addr[31:INDEX_BITS+2];
      data_mem[fill_idx] <= bus.mc_data;
    end
  end
endmodule
